countdown_timer: RTL
====================

# countdown_timer

Loadable down-counter with terminal-count detection. It is the decrementing counterpart of the team's enable-gated up counter: software or a controlling FSM loads a preset, and the block counts toward zero one step per enabled clock. At zero it emits a single-cycle terminal-count pulse. It sits beside the up counter in the counter lab datapath and provides delay, timeout and period generation.

## Interface
- WIDTH, default 8: width of preset and count.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-low; sampled on rising edge of clk.
- load  input  1  load strobe; captures preset and starts a countdown.
- preset  input  WIDTH  start value, sampled only when load=1.
- en  input  1  count enable; one decrement per cycle while high in RUN.
- count  output  WIDTH  current counter value, registered.
- busy  output  1  high while in RUN, registered.
- tc  output  1  terminal-count pulse, registered, exactly one cycle wide.

## Operation
- Two-state FSM:
  - IDLE: count holds; busy=0.
  - RUN: busy=1.
- Priority per cycle: rst low > load > en.
- Reset (rst=0 at an edge):
  - count=0, busy=0, tc=0, state IDLE.
  - Reload register (if configured) = 0.
  - Reset overrides everything, including mid-countdown.
- load=1, any state:
  - count<=preset.
  - If preset≠0: state<=RUN, tc<=0.
  - If preset=0: state<=IDLE, tc<=1 (immediate expiry).
  - A load in RUN restarts the countdown; the in-flight terminal is discarded.
- RUN, load=0, en=1:
  - If count>1: count<=count-1, tc<=0.
  - If count=1: terminal event; count<=0, tc<=1, state<=IDLE (non-reload build).
- RUN, load=0, en=0: count, state hold; tc<=0.
- IDLE, load=0: everything holds; en ignored; tc<=0.
- Arithmetic: unsigned, modulo 2^WIDTH, but count never decrements below 0. There is no wrap-around from 0 to all-ones.
- tc is high for exactly one cycle per terminal event. It is never held.

## Timing
- Load-to-busy latency: 1 cycle (busy is high in the cycle after the load edge).
- Preset N≥1 with en held high: tc is high in the cycle after the N-th enabled edge following the load. count and busy update on that same edge.
- Example, preset=3, load at edge 0, en=1 from edge 1:
  - After edges 1, 2, 3, count = 2, 1, 0.
  - After edge 3: tc=1, busy=0.
  - After edge 4: tc=0.
- en gaps stretch the countdown cycle-for-cycle; no decrement is lost or duplicated.
- Maximum preset (all-ones) takes 2^WIDTH−1 enabled cycles.

## Configuration
- Macro COUNTDOWN_AUTORELOAD_EN.
- Defined:
  - A WIDTH-bit reload register captures preset on every load.
  - At the terminal event: count<=reload, tc<=1, state stays RUN, busy stays 1.
  - Period = preset enabled cycles; count never shows 0 during free-run.
  - A load with preset=0 pulses tc, stops in IDLE, and clears reload.
  - A new load replaces the reload value.
- Undefined:
  - No reload register; the block is one-shot as described above.
  - The terminal event returns to IDLE with count=0.

## Test plan
- Reset: drive rst=0 for 2 edges during RUN with count=5 → count=0, busy=0, tc=0; load asserted in the same cycle is ignored.
- One-shot: WIDTH=8, preset=3, load then en=1 → count 3,2,1,0; tc=1 for exactly one cycle after the third enabled edge; busy falls on the same edge.
- Enable gaps: preset=4, en pattern 1,0,0,1,1,0,1 → tc after the 7th cycle; count holds during en=0.
- Zero and restart:
  - load preset=0 → tc=1 next cycle, busy stays 0.
  - In RUN at count=2, load preset=10 → count=10, no tc.
- Boundary: preset=8'hFF, en=1 → tc after exactly 255 enabled edges; count never reaches 8'hFF again after load.
- Autoreload (COUNTDOWN_AUTORELOAD_EN defined): preset=2, en=1 → count 2,1,2,1…; tc every 2nd cycle; busy stays 1; load preset=0 stops the block with one tc.

Source files
------------

// File: rtl/countdown_timer.sv
// Loadable down-counter with a one-cycle terminal-count pulse.
// Define COUNTDOWN_AUTORELOAD_EN to make the counter free-run by reloading the last preset.
module countdown_timer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] preset,
   input  logic             en,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             tc
);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             tc_q, tc_d;

`ifdef COUNTDOWN_AUTORELOAD_EN
   logic [WIDTH-1:0] reload_q, reload_d;
`endif

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      tc_d    = 1'b0;
`ifdef COUNTDOWN_AUTORELOAD_EN
      reload_d = reload_q;
`endif
      if (load) begin
         count_d = preset;
`ifdef COUNTDOWN_AUTORELOAD_EN
         reload_d = preset;
`endif
         if (preset != '0) begin
            state_d = StRun;
         end else begin
            // A zero preset expires immediately without ever entering RUN.
            state_d = StIdle;
            tc_d    = 1'b1;
         end
      end else begin
         unique case (state_q)
            StRun: begin
               if (en) begin
                  if (count_q > WIDTH'(1)) begin
                     count_d = count_q - WIDTH'(1);
                  end else begin
                     tc_d = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                     count_d = reload_q;
`else
                     count_d = '0;
                     state_d = StIdle;
`endif
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= StIdle;
         count_q <= '0;
         tc_q    <= 1'b0;
`ifdef COUNTDOWN_AUTORELOAD_EN
         reload_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         tc_q    <= tc_d;
`ifdef COUNTDOWN_AUTORELOAD_EN
         reload_q <= reload_d;
`endif
      end
   end

   assign count = count_q;
   assign busy  = (state_q == StRun);
   assign tc    = tc_q;

endmodule
